// File: rtl/cmp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cmp_arbiter : round-robin sequencer sharing one 4-bit unsigned comparator
// rev 1.0
// ---------------------------------------------------------------------------

module cmp_gt4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   output logic       gt
);
   assign gt = (a > b);
endmodule

module cmp_arbiter #(
   parameter int NREQ = 4,
   parameter int IDW  = (NREQ > 2) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [4*NREQ-1:0] req_a,
   input  logic [4*NREQ-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic              rsp_gt,
   output logic [IDW-1:0]    rsp_id,
   output logic [7:0]        op_count
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CMP  = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [IDW-1:0] ptr;
   logic [IDW-1:0] ptr_nx;
   logic [IDW-1:0] id_r;
   logic [IDW-1:0] pick_id;
   logic           pick_vld;
   logic [3:0]     pick_a;
   logic [3:0]     pick_b;
   logic [3:0]     op_a;
   logic [3:0]     op_b;
   logic           cmp_gt;

   // Search from ptr upward with wrap; descending loop so the nearest hit wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_id  = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(ptr) + k) % NREQ]) begin
            pick_vld = 1'b1;
            pick_id  = IDW'((int'(ptr) + k) % NREQ);
         end
      end
   end

   assign pick_a = req_a[4*int'(pick_id) +: 4];
   assign pick_b = req_b[4*int'(pick_id) +: 4];
   assign ptr_nx = (int'(pick_id) == NREQ - 1) ? '0 : pick_id + 1'b1;

   cmp_gt4 u_cmp (
      .a  (op_a),
      .b  (op_b),
      .gt (cmp_gt)
   );

   // Grant is suppressed while reset is held, since state already reads IDLE.
   always_comb begin
      req_ready = '0;
      if (rst_n && (state == S_IDLE) && pick_vld) begin
         req_ready[pick_id] = 1'b1;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (pick_vld) state_nx = S_CMP;
         S_CMP:   state_nx = S_RESP;
         S_RESP:  if (rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         op_a      <= 4'd0;
         op_b      <= 4'd0;
         id_r      <= '0;
         rsp_valid <= 1'b0;
         rsp_gt    <= 1'b0;
         rsp_id    <= '0;
         op_count  <= 8'd0;
      end else begin
         case (state)
            S_IDLE: begin
               if (pick_vld) begin
                  op_a <= pick_a;
                  op_b <= pick_b;
                  id_r <= pick_id;
                  ptr  <= ptr_nx;
               end
            end
            S_CMP: begin
               rsp_gt    <= cmp_gt;
               rsp_id    <= id_r;
               rsp_valid <= 1'b1;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  op_count  <= op_count + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cmp_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cmp_arbiter : randomized + directed self-checking bench for cmp_arbiter
// rev 1.0
// ---------------------------------------------------------------------------
module tb_cmp_arbiter;
   localparam int NREQ = 4;
   localparam int IDW  = 2;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NREQ-1:0]   req_valid = '0;
   logic [4*NREQ-1:0] req_a = '0;
   logic [4*NREQ-1:0] req_b = '0;
   logic [NREQ-1:0]   req_ready;
   logic              rsp_valid;
   logic              rsp_ready = 1'b0;
   logic              rsp_gt;
   logic [IDW-1:0]    rsp_id;
   logic [7:0]        op_count;

   int total = 0;
   int bad   = 0;

   // reference model: free/busy arbiter, pending result, visible response
   int         m_ptr = 0;
   bit         m_busy = 0;
   bit         m_vis = 0;
   bit         m_pgt = 0;
   int         m_pid = 0;
   bit         m_gt = 0;
   int         m_id = 0;
   int         m_cnt = 0;
   int         cyc = 0;
   int         gq_id[$];
   int         gq_cyc[$];
   logic [NREQ-1:0] hs_last = '0;

   always #5 clk = ~clk;

   cmp_arbiter #(.NREQ(NREQ)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_gt    (rsp_gt),
      .rsp_id    (rsp_id),
      .op_count  (op_count)
   );

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] v, input int p);
      for (int k = 0; k < NREQ; k++) begin
         if (v[(p + k) % NREQ]) return (p + k) % NREQ;
      end
      return -1;
   endfunction

   // single compare process: model prediction vs DUT, once per cycle
   always @(negedge clk) begin
      int g;
      int e_rdy;
      int ea;
      int eb;
      cyc++;
      if (!rst_n) begin
         m_ptr = 0; m_busy = 0; m_vis = 0; m_gt = 0; m_id = 0; m_cnt = 0;
         chk("rst_req_ready", int'(req_ready), 0);
         chk("rst_rsp_valid", int'(rsp_valid), 0);
         chk("rst_rsp_gt",    int'(rsp_gt), 0);
         chk("rst_rsp_id",    int'(rsp_id), 0);
         chk("rst_op_count",  int'(op_count), 0);
         hs_last = '0;
      end else begin
         g     = m_busy ? -1 : pick(req_valid, m_ptr);
         e_rdy = (g >= 0) ? (1 << g) : 0;
         chk("req_ready", int'(req_ready), e_rdy);
         chk("rsp_valid", int'(rsp_valid), int'(m_vis));
         chk("rsp_gt",    int'(rsp_gt), int'(m_gt));
         chk("rsp_id",    int'(rsp_id), m_id);
         chk("op_count",  int'(op_count), m_cnt);
         hs_last = req_valid & req_ready;
         if (g >= 0) begin
            ea     = int'(req_a[4*g +: 4]);
            eb     = int'(req_b[4*g +: 4]);
            m_pgt  = (ea > eb);
            m_pid  = g;
            m_busy = 1;
            m_ptr  = (g + 1) % NREQ;
            gq_id.push_back(g);
            gq_cyc.push_back(cyc);
         end else if (m_busy && !m_vis) begin
            m_vis = 1; m_gt = m_pgt; m_id = m_pid;
         end else if (m_vis && rsp_ready) begin
            m_vis = 0; m_busy = 0; m_cnt = (m_cnt + 1) % 256;
         end
      end
   end

   task automatic do_reset();
      @(posedge clk); #2;
      rst_n = 1'b0; req_valid = '0; rsp_ready = 1'b0;
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   // one transaction with literal expectations; returns at the negedge of T+2
   task automatic one_op(input int i, input int a, input int b, input int exp_gt,
                         input bit hold, input string nm);
      int n;
      @(posedge clk); #2;
      req_valid = '0;
      req_valid[i] = 1'b1;
      req_a[4*i +: 4] = a[3:0];
      req_b[4*i +: 4] = b[3:0];
      rsp_ready = !hold;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!req_ready[i] && n < 10);
      chk({nm, "_grant"}, int'(req_ready), 1 << i);
      @(posedge clk); #2 req_valid[i] = 1'b0;
      @(negedge clk);
      chk({nm, "_lat_t1"}, int'(rsp_valid), 0);
      @(negedge clk);
      chk({nm, "_lat_t2"}, int'(rsp_valid), 1);
      chk({nm, "_gt"},     int'(rsp_gt), exp_gt);
      chk({nm, "_id"},     int'(rsp_id), i);
   endtask

   initial begin
      int cnt0;
      int n;
      bit hit;

      // reset holds req_ready low even with requests pending
      req_valid = 4'hF;
      @(negedge clk);
      chk("rst_ready_lit", int'(req_ready), 0);
      do_reset();

      one_op(0, 9, 3, 1, 1'b0, "t1");
      @(negedge clk);
      chk("t1_count", int'(op_count), 1);
      chk("t1_done",  int'(rsp_valid), 0);

      one_op(2, 3, 9, 0, 1'b0, "lt");
      one_op(2, 7, 7, 0, 1'b0, "eq");
      one_op(2, 15, 0, 1, 1'b0, "max");
      @(negedge clk);
      chk("t2_count", int'(op_count), 4);

      // all requesters valid continuously
      do_reset();
      @(posedge clk); #2;
      gq_id.delete(); gq_cyc.delete();
      req_a = 16'h5A3C; req_b = 16'h4B2D;
      req_valid = 4'hF; rsp_ready = 1'b1;
      repeat (15) @(negedge clk);
      @(posedge clk); #2 req_valid = '0;
      chk("rr_count", gq_id.size(), 5);
      if (gq_id.size() >= 5) begin
         chk("rr_g0", gq_id[0], 0);
         chk("rr_g1", gq_id[1], 1);
         chk("rr_g2", gq_id[2], 2);
         chk("rr_g3", gq_id[3], 3);
         chk("rr_g4", gq_id[4], 0);
         for (int k = 1; k < 5; k++) chk("rr_gap", gq_cyc[k] - gq_cyc[k-1], 3);
      end

      // wrap-around: ptr=2, only 0 and 3 valid
      do_reset();
      one_op(1, 4, 2, 1, 1'b0, "wr");
      @(posedge clk); #2;
      gq_id.delete(); gq_cyc.delete();
      req_valid = 4'b1001;
      repeat (7) @(negedge clk);
      @(posedge clk); #2 req_valid = '0;
      chk("wrap_n", int'(gq_id.size() >= 2), 1);
      if (gq_id.size() >= 2) begin
         chk("wrap_first",  gq_id[0], 3);
         chk("wrap_second", gq_id[1], 0);
      end

      // consumer stall in RESP
      do_reset();
      one_op(1, 12, 5, 1, 1'b1, "hold");
      cnt0 = int'(op_count);
      @(posedge clk); #2 req_valid[3] = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("hold_valid", int'(rsp_valid), 1);
         chk("hold_gt",    int'(rsp_gt), 1);
         chk("hold_id",    int'(rsp_id), 1);
         chk("hold_ready", int'(req_ready), 0);
         chk("hold_count", int'(op_count), cnt0);
      end
      @(posedge clk); #2 rsp_ready = 1'b1;
      @(negedge clk);
      chk("hold_last", int'(rsp_valid), 1);
      @(negedge clk);
      chk("hold_clr",   int'(rsp_valid), 0);
      chk("hold_cnt1",  int'(op_count), cnt0 + 1);
      chk("hold_regnt", int'(req_ready), 4'b1000);
      @(posedge clk); #2 req_valid = '0;

      // async reset while in CMP
      do_reset();
      one_op(3, 15, 0, 1, 1'b0, "pre");
      @(posedge clk); #2;
      req_valid[2] = 1'b1; req_a[11:8] = 4'd8; req_b[11:8] = 4'd1;
      n = 0;
      do begin
         @(negedge clk); n++;
      end while (!req_ready[2] && n < 10);
      chk("cmp_grant", int'(req_ready), 4'b0100);
      chk("cmp_precnt", int'(op_count), 1);
      @(posedge clk); #2 req_valid = '0;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", int'(rsp_valid), 0);
      chk("arst_gt",    int'(rsp_gt), 0);
      chk("arst_id",    int'(rsp_id), 0);
      chk("arst_count", int'(op_count), 0);
      chk("arst_ready", int'(req_ready), 0);
      @(posedge clk); #2 rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         chk("arst_norsp", int'(rsp_valid), 0);
      end
      @(posedge clk); #2 req_valid = 4'b1010;
      @(negedge clk);
      chk("arst_lowest", int'(req_ready), 4'b0010);
      @(posedge clk); #2 req_valid = '0;

      // randomized traffic
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #2;
         for (int i = 0; i < NREQ; i++) begin
            if (!req_valid[i] || hs_last[i]) begin
               req_valid[i]    = 1'($urandom % 2);
               req_a[4*i +: 4] = 4'($urandom);
               req_b[4*i +: 4] = 4'($urandom);
            end else if ($urandom % 16 == 0) begin
               req_valid[i] = 1'b0;
            end
         end
         rsp_ready = ($urandom % 4) != 0;
      end

      // op_count wrap after 256 completions
      do_reset();
      @(posedge clk); #2;
      req_valid = 4'b0001; req_a[3:0] = 4'd2; req_b[3:0] = 4'd6; rsp_ready = 1'b1;
      n = 0;
      while (op_count != 8'd255 && n < 1000) begin
         @(negedge clk); n++;
      end
      hit = (op_count == 8'd255);
      chk("wrap_reach255", int'(hit), 1);
      n = 0;
      while (op_count == 8'd255 && n < 10) begin
         @(negedge clk); n++;
      end
      chk("wrap_zero", int'(op_count), 0);
      @(posedge clk); #2 req_valid = '0;
      repeat (4) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cmp_arbiter.md
# cmp_arbiter

Round-robin arbiter and sequencer that shares a single 4-bit unsigned greater-than comparator among NREQ requesters. Each requester presents an operand pair under a valid/ready handshake. The block grants one requester at a time, registers the operands into the shared comparator, and returns the registered `gt` result tagged with the requester index. It sits between the client datapaths and the one comparator instance, so the comparator is never duplicated per client.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, derived as max(1, $clog2(NREQ)), width of the requester index.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- req_valid  input  NREQ  bit i set means requester i holds a pair to compare.
- req_a  input  4*NREQ  operand a of requester i is at bits [4i+3:4i].
- req_b  input  4*NREQ  operand b of requester i is at bits [4i+3:4i].
- req_ready  output  NREQ  one-hot grant/accept; a transfer occurs on a cycle where req_valid[i] & req_ready[i].
- rsp_valid  output  1  a result is held on rsp_gt and rsp_id.
- rsp_ready  input  1  the consumer accepts the result.
- rsp_gt  output  1  1 when a > b (unsigned) for the granted pair.
- rsp_id  output  IDW  index of the requester that owns the result.
- op_count  output  8  count of completed responses; wraps modulo 256.

## Operation
- The block instantiates exactly one 4-bit unsigned greater-than comparator (a, b in; gt out). Its a and b inputs are driven only from the internal operand registers op_a and op_b.
- FSM states:
  - IDLE: if any req_valid bit is set, the round-robin pick g is the first set bit searching from ptr upward, wrapping modulo NREQ.
    - req_ready[g] = 1 (combinational, IDLE only); op_a, op_b and id_r latch requester g's operands.
    - ptr <= (g+1) mod NREQ; next state CMP.
    - With no req_valid set, the block stays in IDLE and req_ready = 0.
  - CMP: rsp_gt <= comparator gt, rsp_id <= id_r, rsp_valid <= 1; next state RESP.
  - RESP: rsp_valid, rsp_gt and rsp_id are held stable.
    - On rsp_ready = 1: rsp_valid <= 0, op_count <= op_count + 1, next state IDLE.
    - Otherwise the block stays in RESP.
- req_ready is 0 in CMP and RESP. At most one req_ready bit is ever set.
- Requesters must hold req_valid and operands stable until their handshake. A requester may drop req_valid without a handshake; no error is flagged.
- Equal operands give rsp_gt = 0. Operands are unsigned: 4'hF > 4'h0.
- The round-robin pointer ptr advances only on a grant, never on idle cycles.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, ptr = 0, op_a = op_b = 0, id_r = 0, rsp_valid = 0, rsp_gt = 0, rsp_id = 0, op_count = 0. req_ready is 0 while in reset.
- Reset mid-operation (CMP or RESP): the pending operation and response are discarded, with no handshake and no count. The first grant after reset goes to the lowest-index valid requester.
- Latency: handshake in cycle T, rsp_valid = 1 from cycle T+2.
- rsp_ready sampled high in cycle R: rsp_valid = 0 in cycle R+1 and the block is in IDLE. The next grant can occur in R+1.
- Peak throughput is one comparison per 3 cycles.
- rsp_ready held high continuously: each response is visible for exactly one cycle.
- op_count increments on the same edge that clears rsp_valid. 255 + 1 = 0.
- rsp_ready while rsp_valid = 0 has no effect.

## Test plan
- After reset, requester 0 presents a=9, b=3 → req_ready = 4'b0001 in cycle T; rsp_valid, rsp_gt = 1, rsp_id = 0 at T+2; op_count = 1 after rsp_ready.
- Requester 2 presents a=3, b=9, then a=7, b=7 → rsp_gt = 0 with rsp_id = 2 both times; a=15, b=0 → rsp_gt = 1.
- All four requesters valid continuously, rsp_ready = 1 → grants in order 0, 1, 2, 3, 0, each 3 cycles apart. rsp_id follows the same sequence.
- ptr = 2 with only requesters 0 and 3 valid → grant goes to 3, then 0 (wrap-around).
- rsp_ready held low for 5 cycles during RESP → rsp_gt and rsp_id stay stable, req_ready stays 0, op_count is unchanged. Response completes in the cycle rsp_ready rises.
- rst_n pulsed low in CMP → all outputs go to 0 immediately and no response is issued. Separately, 256 completed operations → op_count returns to 0.
